// File: rtl/exe_alu_pipe.sv
// exe_alu_pipe: registered execute-stage ALU with valid/ready handshakes on
// both sides and ARM-style {N,Z,C,V} status generation.
// Optional feature macro: ALU_MUL_EN adds an iterative shift-add multiplier
// (opcode 1010) that takes WIDTH cycles per operation.
module exe_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Val1,
  input  logic [WIDTH-1:0] Val2,
  input  logic [CMD_W-1:0] EXE_CMD,
  input  logic [3:0]       SR,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Status,
  output logic             busy
);

  localparam logic [CMD_W-1:0] CMD_MOV = CMD_W'(4'b0001);
  localparam logic [CMD_W-1:0] CMD_MVN = CMD_W'(4'b1001);
  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(4'b0010);
  localparam logic [CMD_W-1:0] CMD_ADC = CMD_W'(4'b0011);
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(4'b0100);
  localparam logic [CMD_W-1:0] CMD_SBC = CMD_W'(4'b0101);
  localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(4'b0110);
  localparam logic [CMD_W-1:0] CMD_ORR = CMD_W'(4'b0111);
  localparam logic [CMD_W-1:0] CMD_EOR = CMD_W'(4'b1000);
`ifdef ALU_MUL_EN
  localparam logic [CMD_W-1:0] CMD_MUL = CMD_W'(4'b1010);
  localparam int               CNT_W   = $clog2(WIDTH + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } state_t;

  state_t state;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic             cin;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_status;

  // N and Z of the incoming status are never consumed; results recompute them.
  logic unused_sr_nz;
  assign unused_sr_nz = ^SR[3:2];

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mul_cv;
  logic             busy_q;

  assign busy     = busy_q;
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`else
  assign busy = 1'b0;
`endif

  // Ready whenever idle, or when the held result is being consumed this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
    end
  end

  assign accept = in_valid && in_ready;

  // Single-cycle datapath: result plus carry/overflow from a WIDTH+1-bit sum.
  always_comb begin
    sum     = '0;
    cin     = 1'b0;
    alu_res = '0;
    alu_c   = SR[1];
    alu_v   = SR[0];
    case (EXE_CMD)
      CMD_MOV: alu_res = Val2;
      CMD_MVN: alu_res = ~Val2;
      CMD_ADD, CMD_ADC: begin
        cin     = (EXE_CMD == CMD_ADC) ? SR[1] : 1'b0;
        sum     = {1'b0, Val1} + {1'b0, Val2} + {{WIDTH{1'b0}}, cin};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (Val1[WIDTH-1] == Val2[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != Val1[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        // Subtract as Val1 + ~Val2 + cin so the carry out is the ARM no-borrow flag.
        cin     = (EXE_CMD == CMD_SUB) ? 1'b1 : SR[1];
        sum     = {1'b0, Val1} + {1'b0, ~Val2} + {{WIDTH{1'b0}}, cin};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (Val1[WIDTH-1] != Val2[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != Val1[WIDTH-1]);
      end
      CMD_AND: alu_res = Val1 & Val2;
      CMD_ORR: alu_res = Val1 | Val2;
      CMD_EOR: alu_res = Val1 ^ Val2;
      default: alu_res = '0;
    endcase
    alu_status = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
  end

  // Control FSM with registered Result/Status/out_valid and the multiplier iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      Result    <= '0;
      Status    <= '0;
`ifdef ALU_MUL_EN
      busy_q    <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      mul_cv    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (EXE_CMD == CMD_MUL) begin
              mcand     <= Val1;
              mplier    <= Val2;
              acc       <= '0;
              cnt       <= CNT_W'(WIDTH);
              mul_cv    <= SR[1:0];
              busy_q    <= 1'b1;
              out_valid <= 1'b0;
              state     <= S_MUL;
            end else
`endif
            begin
              Result    <= alu_res;
              Status    <= alu_status;
              out_valid <= 1'b1;
              state     <= S_HOLD;
            end
          end else if ((state == S_HOLD) && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            Result    <= acc_next;
            Status    <= {acc_next[WIDTH-1], (acc_next == '0), mul_cv};
            out_valid <= 1'b1;
            busy_q    <= 1'b0;
            state     <= S_HOLD;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_alu_pipe.sv
// tb_exe_alu_pipe: scoreboard bench for exe_alu_pipe. Expected {Result,Status}
// pairs are pushed when an operation is accepted and popped when it appears.
module tb_exe_alu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Val1;
  logic [W-1:0] Val2;
  logic [3:0]   EXE_CMD;
  logic [3:0]   SR;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic [3:0]   Status;
  logic         busy;

  int asserts = 0;
  int fails   = 0;
  logic [W+3:0] sb[$];

  always #5 clk = ~clk;

  exe_alu_pipe #(.WIDTH(W), .CMD_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Val1(Val1), .Val2(Val2), .EXE_CMD(EXE_CMD), .SR(SR),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Status(Status), .busy(busy)
  );

  // Present one operation, wait (bounded) for acceptance, then scramble inputs.
  task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] sr, input logic [W+3:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    EXE_CMD = cmd; Val1 = a; Val2 = b; SR = sr; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    asserts++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_accept: in_ready=%b required 1", in_ready);
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    Val1 = $urandom; Val2 = $urandom; EXE_CMD = 4'($urandom); SR = 4'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Val1 = '0; Val2 = '0; EXE_CMD = '0; SR = '0;
    repeat (3) @(negedge clk);
    asserts++;
    if ({in_ready, out_valid, busy, Status, Result} !== {3'b000, 4'b0000, {W{1'b0}}}) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b Status=%b Result=%h required all zero",
               in_ready, out_valid, busy, Status, Result);
    end
    rst = 1'b0;
    @(negedge clk);
    asserts++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_arith();
    logic [3:0]   c [9];
    logic [W-1:0] a [9];
    logic [W-1:0] b [9];
    logic [3:0]   s [9];
    logic [W+3:0] e [9];
    logic [W+3:0] exp;
    c[0] = 4'b0010; a[0] = 32'hFFFF_FFFF; b[0] = 32'd1; s[0] = 4'b0000; e[0] = {32'h0000_0000, 4'b0110};
    c[1] = 4'b0010; a[1] = 32'h7FFF_FFFF; b[1] = 32'd1; s[1] = 4'b0000; e[1] = {32'h8000_0000, 4'b1001};
    c[2] = 4'b0100; a[2] = 32'd5;         b[2] = 32'd7; s[2] = 4'b0000; e[2] = {32'hFFFF_FFFE, 4'b1000};
    c[3] = 4'b0011; a[3] = 32'd3;         b[3] = 32'd4; s[3] = 4'b0010; e[3] = {32'h0000_0008, 4'b0000};
    c[4] = 4'b0101; a[4] = 32'd10;        b[4] = 32'd3; s[4] = 4'b0000; e[4] = {32'h0000_0006, 4'b0010};
    c[5] = 4'b0100; a[5] = 32'h8000_0000; b[5] = 32'd1; s[5] = 4'b0000; e[5] = {32'h7FFF_FFFF, 4'b0011};
    c[6] = 4'b0110; a[6] = 32'hF0;        b[6] = 32'h3C; s[6] = 4'b0011; e[6] = {32'h0000_0030, 4'b0011};
    c[7] = 4'b0111; a[7] = 32'd0;         b[7] = 32'd0; s[7] = 4'b0001; e[7] = {32'h0000_0000, 4'b0101};
    c[8] = 4'b0000; a[8] = 32'h1234;      b[8] = 32'h5678; s[8] = 4'b0010; e[8] = {32'h0000_0000, 4'b0110};
    for (int i = 0; i < 9; i++) begin
      issue(c[i], a[i], b[i], s[i], e[i]);
      @(negedge clk);
      asserts++;
      if (out_valid !== 1'b1) begin
        fails++;
        $display("FAIL arith_valid[%0d]: out_valid=%b required 1", i, out_valid);
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        asserts++;
        if ({Result, Status} !== exp) begin
          fails++;
          $display("FAIL arith_result[%0d]: Result=%h Status=%b required Result=%h Status=%b",
                   i, Result, Status, exp[W+3:4], exp[3:0]);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      asserts++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL arith_drain[%0d]: out_valid=%b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   c [3];
    logic [W-1:0] b [3];
    logic [W+3:0] e [3];
    logic [W+3:0] exp;
    c[0] = 4'b0001; b[0] = 32'd1; e[0] = {32'h0000_0001, 4'b0000};
    c[1] = 4'b1001; b[1] = 32'd0; e[1] = {32'hFFFF_FFFF, 4'b1000};
    c[2] = 4'b1000; b[2] = 32'd3; e[2] = {32'h0000_0006, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        asserts++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
          fails++;
          $display("FAIL b2b_valid[%0d]: out_valid=%b queued=%0d required valid with pending result",
                   i, out_valid, sb.size());
        end else begin
          exp = sb.pop_front();
          asserts++;
          if ({Result, Status} !== exp) begin
            fails++;
            $display("FAIL b2b_result[%0d]: Result=%h Status=%b required Result=%h Status=%b",
                     i, Result, Status, exp[W+3:4], exp[3:0]);
          end
        end
      end
      if (i < 3) begin
        out_ready = 1'b1; EXE_CMD = c[i]; Val1 = 32'd5; Val2 = b[i]; SR = 4'b0000; in_valid = 1'b1;
        #1;
        asserts++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, in_ready);
        end else begin
          sb.push_back(e[i]);
        end
      end else begin
        in_valid = 1'b0; out_ready = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      asserts++;
      if ({out_valid, in_ready, Result, Status} !== {2'b10, 32'h0000_0006, 4'b0000}) begin
        fails++;
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b Result=%h Status=%b required 1 0 00000006 0000",
                 k, out_valid, in_ready, Result, Status);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    asserts++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_mul();
    logic [W+3:0] exp;
`ifdef ALU_MUL_EN
    int busy_cnt;
    int n;
    busy_cnt = 0;
    n = 0;
    issue(4'b1010, 32'h0001_0003, 32'd5, 4'b0011, {32'h0005_000F, 4'b0011});
    @(negedge clk);
    n = 1;
    asserts++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mul_in_ready: in_ready=%b required 0", in_ready);
    end
    while (!out_valid && n <= W + 8) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    asserts++;
    if (busy_cnt != W || n != W + 1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL mul_latency: busy cycles=%0d valid at=%0d required busy=%0d valid at=%0d",
               busy_cnt, n, W, W + 1);
    end
`else
    issue(4'b1010, 32'h0001_0003, 32'd5, 4'b0011, {32'h0000_0000, 4'b0111});
    @(negedge clk);
    asserts++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mul_undef_valid: out_valid=%b busy=%b required 1 0", out_valid, busy);
    end
`endif
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      asserts++;
      if ({Result, Status} !== exp) begin
        fails++;
        $display("FAIL mul_result: Result=%h Status=%b required Result=%h Status=%b",
                 Result, Status, exp[W+3:4], exp[3:0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_mul_reset();
    logic [W+3:0] exp;
`ifdef ALU_MUL_EN
    issue(4'b1010, 32'h0000_0007, 32'h0000_0009, 4'b0000, {32'h0000_003F, 4'b0000});
    repeat (10) @(negedge clk);
    asserts++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mul_reset_busy: busy=%b required 1", busy);
    end
`else
    issue(4'b0010, 32'd1, 32'd1, 4'b0000, {32'h0000_0002, 4'b0000});
    @(negedge clk);
    asserts++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold_valid: out_valid=%b required 1", out_valid);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    asserts++;
    if ({out_valid, busy, Result} !== {2'b00, {W{1'b0}}}) begin
      fails++;
      $display("FAIL mid_reset: out_valid=%b busy=%b Result=%h required 0 0 0", out_valid, busy, Result);
    end
    rst = 1'b0;
    issue(4'b0010, 32'd2, 32'd2, 4'b0000, {32'h0000_0004, 4'b0000});
    @(negedge clk);
    asserts++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      fails++;
      $display("FAIL post_reset_valid: out_valid=%b required 1", out_valid);
    end else begin
      exp = sb.pop_front();
      asserts++;
      if ({Result, Status} !== exp) begin
        fails++;
        $display("FAIL post_reset_add: Result=%h Status=%b required Result=%h Status=%b",
                 Result, Status, exp[W+3:4], exp[3:0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_mul();
    test_mul_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
